// File: rtl/rv32i_mtimer_pkg.sv
// Shared register map, CTRL field positions and timer width for the machine timer.
// The address decoder lives here so every user agrees on one map.
package rv32i_mtimer_pkg;

  localparam int MTIME_W      = 48;
  localparam int MTIME_HI_W   = MTIME_W - 32;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  localparam logic [4:0] OFF_MTIME_LO = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI = 5'h04;
  localparam logic [4:0] OFF_CMP_LO   = 5'h08;
  localparam logic [4:0] OFF_CMP_HI   = 5'h0C;
  localparam logic [4:0] OFF_CTRL     = 5'h10;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_CTRL,
    REG_NONE
  } reg_sel_t;

  function automatic reg_sel_t decode_addr(input logic [4:0] addr);
    logic [4:0] word;
    word = addr & 5'b11100;
    case (word)
      OFF_MTIME_LO: return REG_MTIME_LO;
      OFF_MTIME_HI: return REG_MTIME_HI;
      OFF_CMP_LO:   return REG_CMP_LO;
      OFF_CMP_HI:   return REG_CMP_HI;
      OFF_CTRL:     return REG_CTRL;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mtimer_prescaler.sv
// Divide-by-(DIV+1) tick generator; holds while disabled, restarts on clear.
module rv32i_mtimer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = en && (count == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/rv32i_mtimer.sv
// Memory-mapped 48-bit machine timer with compare interrupt and coherent LO/HI reads.
module rv32i_mtimer
  import rv32i_mtimer_pkg::*;
#(
  parameter int                 PRESCALE_W = 8,
  parameter logic [MTIME_W-1:0] CMP_RESET  = 48'hFFFF_FFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [4:0]         req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [MTIME_W-1:0] mtime,
  output logic               timer_interrupt
);

  reg_sel_t                sel;
  logic                    wr;
  logic                    rd;
  logic                    tick;
  logic                    ctrl_en;
  logic [PRESCALE_W-1:0]   ctrl_div;
  logic [MTIME_W-1:0]      mtimecmp;
  logic [MTIME_HI_W-1:0]   shadow;
  logic [31:0]             rdata_p0;
  logic                    err_p0;

  function automatic logic [31:0] ctrl_word(input logic en, input logic [PRESCALE_W-1:0] div);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT] = en;
    w[CTRL_DIV_LSB +: PRESCALE_W] = div;
    return w;
  endfunction

  assign sel = decode_addr(req_addr);
  assign wr  = req_valid && req_we;
  assign rd  = req_valid && !req_we;

  rv32i_mtimer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_en),
    .div  (ctrl_div),
    .clear(wr && (sel == REG_CTRL)),
    .tick (tick)
  );

  // Stage p0: read mux and error decode, registered into the response below.
  always_comb begin
    rdata_p0 = '0;
    err_p0   = 1'b0;
    if (req_valid) begin
      err_p0 = (sel == REG_NONE);
      if (!req_we) begin
        case (sel)
          REG_MTIME_LO: rdata_p0 = mtime[31:0];
          REG_MTIME_HI: rdata_p0 = {{(32-MTIME_HI_W){1'b0}}, shadow};
          REG_CMP_LO:   rdata_p0 = mtimecmp[31:0];
          REG_CMP_HI:   rdata_p0 = {{(32-MTIME_HI_W){1'b0}}, mtimecmp[MTIME_W-1:32]};
          REG_CTRL:     rdata_p0 = ctrl_word(ctrl_en, ctrl_div);
          default:      rdata_p0 = '0;
        endcase
      end
    end
  end

  // A software write to either half overrides a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr && (sel == REG_MTIME_LO)) begin
      mtime <= {mtime[MTIME_W-1:32], req_wdata};
    end else if (wr && (sel == REG_MTIME_HI)) begin
      mtime <= {req_wdata[MTIME_HI_W-1:0], mtime[31:0]};
    end else if (tick) begin
      mtime <= mtime + MTIME_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= CMP_RESET;
      ctrl_en  <= 1'b1;
      ctrl_div <= '0;
      shadow   <= '0;
    end else begin
      if (wr && (sel == REG_CMP_LO)) mtimecmp <= {mtimecmp[MTIME_W-1:32], req_wdata};
      if (wr && (sel == REG_CMP_HI)) mtimecmp <= {req_wdata[MTIME_HI_W-1:0], mtimecmp[31:0]};
      if (wr && (sel == REG_CTRL)) begin
        ctrl_en  <= req_wdata[CTRL_EN_BIT];
        ctrl_div <= req_wdata[CTRL_DIV_LSB +: PRESCALE_W];
      end
      if (rd && (sel == REG_MTIME_LO)) shadow <= mtime[MTIME_W-1:32];
    end
  end

  // Stage p1: registered response and interrupt level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      timer_interrupt <= 1'b0;
    end else begin
      resp_valid      <= req_valid;
      resp_rdata      <= rdata_p0;
      resp_err        <= err_p0;
      timer_interrupt <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_rv32i_mtimer.sv
// Directed bench for rv32i_mtimer: scoreboard on the response bus plus cycle-exact timer checks.
module tb_rv32i_mtimer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [47:0] mtime;
  logic        timer_interrupt;

  localparam logic [4:0] A_LO   = 5'h00;
  localparam logic [4:0] A_HI   = 5'h04;
  localparam logic [4:0] A_CLO  = 5'h08;
  localparam logic [4:0] A_CHI  = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  rv32i_mtimer #(
    .PRESCALE_W(8),
    .CMP_RESET (48'hFFFF_FFFF_FFFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mtime          (mtime),
    .timer_interrupt(timer_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    access(1'b1, addr, data, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp);
    access(1'b0, addr, 32'h0, exp, 1'b0);
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("resp_err", 64'(resp_err), 64'(e[32]));
          check("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mtime", 64'(mtime), 64'h0);
    check("rst_irq", 64'(timer_interrupt), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_rdata", 64'(resp_rdata), 64'h0);
    check("rst_err", 64'(resp_err), 64'h0);
    rst = 1'b0;

    repeat (10) @(negedge clk);
    check("count10", 64'(mtime), 64'd10);
    check("count10_irq", 64'(timer_interrupt), 64'h0);

    wr(A_CTRL, 32'h0000_0301);
    check("div3_start", 64'(mtime), 64'd12);
    repeat (40) @(negedge clk);
    check("div3_40cyc", 64'(mtime), 64'd22);
    rd(A_CTRL, 32'h0000_0301);

    wr(A_CTRL, 32'h0);
    wr(A_HI, 32'h0);
    wr(A_LO, 32'h0);
    wr(A_CHI, 32'h0);
    wr(A_CLO, 32'd20);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      check("cmp_mtime", 64'(mtime), 64'(k));
      check("cmp_irq", 64'(timer_interrupt), 64'(k >= 21));
    end
    wr(A_CLO, 32'd100);
    check("cmp100_mtime", 64'(mtime), 64'd24);
    check("cmp100_irq_lag", 64'(timer_interrupt), 64'h1);
    @(negedge clk);
    check("cmp100_irq_clear", 64'(timer_interrupt), 64'h0);

    wr(A_CTRL, 32'h0);
    wr(A_HI, 32'h0);
    wr(A_LO, 32'hFFFF_FFFF);
    rd(A_LO, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    rd(A_HI, 32'h0);
    rd(A_LO, 32'h0000_0002);
    rd(A_HI, 32'h0000_0001);

    wr(A_CTRL, 32'h0);
    wr(A_CHI, 32'h0);
    wr(A_CLO, 32'd5);
    wr(A_HI, 32'h0000_FFFF);
    wr(A_LO, 32'hFFFF_FFFF);
    check("wrap_pre_mtime", 64'(mtime), 64'hFFFF_FFFF_FFFF);
    check("wrap_pre_irq", 64'(timer_interrupt), 64'h1);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("wrap_mtime", 64'(mtime), 64'(k - 1));
      check("wrap_irq", 64'(timer_interrupt), 64'((k == 1) || (k >= 7)));
    end

    access(1'b0, 5'h14, 32'h0, 32'h0, 1'b1);
    access(1'b1, 5'h18, 32'hDEAD_BEEF, 32'h0, 1'b1);
    rd(A_CLO, 32'd5);
    rd(A_CHI, 32'h0);
    rd(A_CTRL, 32'h1);

    wr(A_LO, 32'h0000_1234);
    check("tick_wr_lo", 64'(mtime), 64'h0000_0000_1234);
    wr(A_HI, 32'h0000_00AB);
    check("tick_wr_hi", 64'(mtime), 64'h00AB_0000_1235);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_LO;
    #2 rst = 1'b1;
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", 64'(resp_valid), 64'h0);
    check("midrst_mtime", 64'(mtime), 64'h0);
    rst = 1'b0;
    strobes = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) strobes++;
    end
    check("midrst_no_resp", 64'(strobes), 64'h0);
    rd(A_CTRL, 32'h1);
    rd(A_CHI, 32'h0000_FFFF);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
